// File: rtl/fft_pkg.sv
// Shared FFT front-end definitions: sample width, bank states and P-bit bit reversal.
package fft_pkg;

  localparam int MAX_P = 6;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_e;

  function automatic int data_w(input int n);
    return 1 << n;
  endfunction

  // A bank that is FULL or DRAINING cannot take new samples.
  function automatic logic bank_busy(input bank_state_e s);
    return (s == BANK_FULL) || (s == BANK_DRAINING);
  endfunction

  // Reverses the low p bits of v; bits at or above p come back as zero.
  function automatic logic [MAX_P-1:0] bit_rev(input logic [MAX_P-1:0] v, input int p);
    logic [MAX_P-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_P; i++)
      for (int j = 0; j < MAX_P; j++)
        if (i < p && j == p - 1 - i) r[j] = v[i];
    return r;
  endfunction

endpackage

// File: rtl/fft_pp_bank.sv
// One ping-pong bank: single write port, two combinational read ports, 2**P words.
module fft_pp_bank import fft_pkg::*; #(
  parameter int N = 4,
  parameter int P = 3
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [P-1:0]         waddr_i,
  input  logic [data_w(N)-1:0] wdata_i,
  input  logic [P-1:0]         raddr_a_i,
  input  logic [P-1:0]         raddr_b_i,
  output logic [data_w(N)-1:0] rdata_a_o,
  output logic [data_w(N)-1:0] rdata_b_o
);

  localparam int W = data_w(N);

  logic [W-1:0] mem_q [2**P];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Reads are unregistered so the top's output registers are the only read stage.
  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/fft_in_buf.sv
// Ping-pong input buffer pairing samples for the first butterfly stage.
// Define FFT_IN_BUF_BITREV_EN for bit-reversed pair order; natural order otherwise.
module fft_in_buf import fft_pkg::*; #(
  parameter int N = 4,
  parameter int P = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [data_w(N)-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [data_w(N)-1:0] a,
  output logic [data_w(N)-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sop
);

  localparam int W     = data_w(N);
  localparam int PW    = (P > 1) ? P - 1 : 1;
  localparam int PAIRS = 1 << (P - 1);

  bank_state_e   state_q [2];
  bank_state_e   state_d [2];
  logic          wr_bank_q, wr_bank_d;
  logic [P-1:0]  wr_idx_q, wr_idx_d;
  logic          rd_bank_q, rd_bank_d;
  logic [PW-1:0] pair_q, pair_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic          sop_q, sop_d, ov_q, ov_d;

  logic          wr_en, load, last_done, ld_bank;
  logic [PW-1:0] ld_pair;
  logic [P-1:0]  nat_a, nat_b, rd_addr_a, rd_addr_b;
  logic [W-1:0]  rd_a [2];
  logic [W-1:0]  rd_b [2];

  assign in_ready = !(bank_busy(state_q[0]) && bank_busy(state_q[1]));
  assign wr_en    = in_valid && in_ready;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_bank
    fft_pp_bank #(.N(N), .P(P)) u_bank (
      .clk       (clk),
      .we_i      (wr_en && (wr_bank_q == 1'(gi))),
      .waddr_i   (wr_idx_q),
      .wdata_i   (in_data),
      .raddr_a_i (rd_addr_a),
      .raddr_b_i (rd_addr_b),
      .rdata_a_o (rd_a[gi]),
      .rdata_b_o (rd_b[gi])
    );
  end

  // Decide which pair (if any) gets loaded into the output registers this edge.
  always_comb begin
    load      = 1'b0;
    last_done = 1'b0;
    ld_bank   = rd_bank_q;
    ld_pair   = '0;
    if (!ov_q) begin
      load = (state_q[rd_bank_q] == BANK_FULL);
    end else if (out_ready) begin
      if (pair_q == PW'(PAIRS - 1)) begin
        last_done = 1'b1;
        ld_bank   = ~rd_bank_q;
        load      = (state_q[~rd_bank_q] == BANK_FULL);
      end else begin
        load    = 1'b1;
        ld_pair = pair_q + PW'(1);
      end
    end
  end

  always_comb begin
    nat_a = P'({ld_pair, 1'b0});
    nat_b = P'({ld_pair, 1'b1});
`ifdef FFT_IN_BUF_BITREV_EN
    rd_addr_a = P'(bit_rev(MAX_P'(nat_a), P));
    rd_addr_b = P'(bit_rev(MAX_P'(nat_b), P));
`else
    rd_addr_a = nat_a;
    rd_addr_b = nat_b;
`endif
  end

  // Write and read sides always touch different banks, so their updates never collide.
  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_bank_d = rd_bank_q;
    pair_d    = pair_q;
    a_d       = a_q;
    b_d       = b_q;
    sop_d     = sop_q;
    ov_d      = ov_q;
    if (wr_en) begin
      if (wr_idx_q == '1) begin
        state_d[wr_bank_q] = BANK_FULL;
        wr_bank_d          = ~wr_bank_q;
        wr_idx_d           = '0;
      end else begin
        state_d[wr_bank_q] = BANK_FILLING;
        wr_idx_d           = wr_idx_q + P'(1);
      end
    end
    if (last_done) begin
      state_d[rd_bank_q] = BANK_EMPTY;
      rd_bank_d          = ~rd_bank_q;
      sop_d              = 1'b0;
      ov_d               = 1'b0;
    end
    if (load) begin
      state_d[ld_bank] = BANK_DRAINING;
      rd_bank_d        = ld_bank;
      pair_d           = ld_pair;
      a_d              = rd_a[ld_bank];
      b_d              = rd_b[ld_bank];
      sop_d            = (ld_pair == '0);
      ov_d             = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q[0] <= BANK_EMPTY;
      state_q[1] <= BANK_EMPTY;
      wr_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      rd_bank_q  <= 1'b0;
      pair_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sop_q      <= 1'b0;
      ov_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_bank_q <= rd_bank_d;
      pair_q    <= pair_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sop_q     <= sop_d;
      ov_q      <= ov_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign sop       = sop_q;
  assign out_valid = ov_q;

endmodule

// File: tb/tb_fft_in_buf.sv
// Directed bench for fft_in_buf (N=4, P=3); expected pair order follows FFT_IN_BUF_BITREV_EN.
`timescale 1ns/1ps
module tb_fft_in_buf;

  localparam int N = 4;
  localparam int P = 3;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data, a, b;
  logic         in_valid, in_ready, out_valid, out_ready, sop;

  fft_in_buf #(.N(N), .P(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sop       (sop)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sop;
  } pair_t;

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         e_ir;
    logic         e_ov;
    logic         e_sop;
    logic [W-1:0] e_a;
    logic [W-1:0] e_b;
  } vec_t;

  pair_t exp_q[$];
  pair_t mon_e;
  int    a_off[4];
  int    b_off[4];
  vec_t  tbl[14];

  task automatic push_frame(input int base);
    pair_t p;
    for (int k = 0; k < 4; k++) begin
      p.a   = W'(base + a_off[k]);
      p.b   = W'(base + b_off[k]);
      p.sop = (k == 0);
      exp_q.push_back(p);
    end
  endtask

  // Every accepted pair is scored in order; a stalled pair must not change.
  logic         mon_en = 1'b0;
  logic         hold_v = 1'b0;
  logic [W-1:0] hold_a, hold_b;
  logic         hold_sop;

  always @(negedge clk) begin
    if (!rst || !mon_en) begin
      hold_v <= 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_a", 32'(a), 32'(hold_a));
        chk("hold_b", 32'(b), 32'(hold_b));
        chk("hold_sop", 32'(sop), 32'(hold_sop));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pair: got a=%0d b=%0d, required no pair", a, b);
        end else begin
          mon_e = exp_q.pop_front();
          $display("pair a=%0d b=%0d sop=%0d", a, b, sop);
          chk("pair_a", 32'(a), 32'(mon_e.a));
          chk("pair_b", 32'(b), 32'(mon_e.b));
          chk("pair_sop", 32'(sop), 32'(mon_e.sop));
        end
      end
      hold_v   <= out_valid && !out_ready;
      hold_a   <= a;
      hold_b   <= b;
      hold_sop <= sop;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    mon_en    = 1'b0;
    exp_q.delete();
    step();
    @(negedge clk);
    chk("rst_a", 32'(a), 32'd0);
    chk("rst_b", 32'(b), 32'd0);
    chk("rst_sop", 32'(sop), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b1;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef FFT_IN_BUF_BITREV_EN
    a_off = '{0, 2, 1, 3};
    b_off = '{4, 6, 5, 7};
`else
    a_off = '{0, 2, 4, 6};
    b_off = '{1, 3, 5, 7};
`endif

    // Frame 1..8 streamed back to back; outputs listed per cycle before that cycle's edge.
    for (int c = 0; c < 14; c++) begin
      tbl[c].iv    = (c < 8);
      tbl[c].d     = (c < 8) ? W'(c + 1) : '0;
      tbl[c].ordy  = 1'b1;
      tbl[c].e_ir  = 1'b1;
      tbl[c].e_ov  = (c >= 9 && c <= 12);
      tbl[c].e_sop = (c == 9);
      tbl[c].e_a   = (c >= 9 && c <= 12) ? W'(1 + a_off[c - 9]) : '0;
      tbl[c].e_b   = (c >= 9 && c <= 12) ? W'(1 + b_off[c - 9]) : '0;
    end

    do_reset();
    for (int c = 0; c < 14; c++) begin
      in_valid  = tbl[c].iv;
      in_data   = tbl[c].d;
      out_ready = tbl[c].ordy;
      @(negedge clk);
      chk("t1_valid", 32'(out_valid), 32'(tbl[c].e_ov));
      chk("t1_in_ready", 32'(in_ready), 32'(tbl[c].e_ir));
      if (tbl[c].e_ov) begin
        chk("t1_sop", 32'(sop), 32'(tbl[c].e_sop));
        chk("t1_a", 32'(a), 32'(tbl[c].e_a));
        chk("t1_b", 32'(b), 32'(tbl[c].e_b));
      end
      step();
    end

    // Back-pressure: 16 samples fill both banks, then drain with no bubble.
    do_reset();
    mon_en = 1'b1;
    push_frame(1);
    push_frame(9);
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      @(negedge clk);
      chk("fill_in_ready", 32'(in_ready), 32'd1);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 16'd99;
      @(negedge clk);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_valid", 32'(out_valid), 32'd1);
      chk("full_a", 32'(a), 32'd1);
      chk("full_b", 32'(b), 32'(1 + b_off[0]));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("drain_valid", 32'(out_valid), 32'd1);
      step();
    end
    @(negedge clk);
    chk("drain_end_valid", 32'(out_valid), 32'd0);
    chk("drain_in_ready", 32'(in_ready), 32'd1);
    wait_drain(4);

    // out_ready toggles every cycle while one frame fills and drains.
    do_reset();
    mon_en = 1'b1;
    push_frame(21);
    for (int c = 0; c < 60 && (c < 8 || exp_q.size() != 0); c++) begin
      in_valid  = (c < 8);
      in_data   = W'(21 + c);
      out_ready = (c % 2 == 1);
      @(negedge clk);
      step();
    end
    in_valid = 1'b0;
    wait_drain(4);

    // Reset after a partial frame; the next frame must start at bank 0, index 0.
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      step();
    end
    in_valid = 1'b0;
    do_reset();
    mon_en    = 1'b1;
    out_ready = 1'b1;
    push_frame(10);
    for (int i = 10; i <= 17; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      step();
    end
    in_valid = 1'b0;
    wait_drain(20);

    // Four frames back to back with out_ready held high: in_ready never drops.
    do_reset();
    mon_en    = 1'b1;
    out_ready = 1'b1;
    for (int f = 0; f < 4; f++) push_frame(40 + 8 * f);
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1;
      in_data  = W'(40 + i);
      @(negedge clk);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      step();
    end
    in_valid = 1'b0;
    wait_drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
